// File: rtl/wled_serializer.sv
// WS2812 line driver: per-LED colour frame buffer plus a free-running NRZ
// refresh engine (latch gap, then NUM_LEDS x 24 bits, MSB of each word first).
module wled_serializer #(
  parameter int CLK_MHZ  = 27,
  parameter int NUM_LEDS = 12,
  parameter int RESET_US = 80
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] rgb_data,
  input  logic [7:0]  led_num,
  input  logic        write,
  output logic        data,
  output logic        busy,
  output logic        frame_done
);

  localparam int T_BIT   = CLK_MHZ * 1250 / 1000;
  localparam int T0H     = CLK_MHZ * 350 / 1000;
  localparam int T1H     = CLK_MHZ * 700 / 1000;
  localparam int T_RST   = CLK_MHZ * RESET_US;
  localparam int CNT_MAX = (T_RST > T_BIT) ? T_RST : T_BIT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [IW-1:0] idx_t;

  localparam cnt_t RST_LAST = cnt_t'(T_RST - 1);
  localparam cnt_t BIT_LAST = cnt_t'(T_BIT - 1);
  localparam cnt_t T0H_C    = cnt_t'(T0H);
  localparam cnt_t T1H_C    = cnt_t'(T1H);
  localparam idx_t LAST_LED = idx_t'(NUM_LEDS - 1);

  // LOAD has no cycles of its own: the fetch happens on the transition edge
  // into SEND, so the encoding is only ever reached through corruption.
  typedef enum logic [1:0] {LATCH, LOAD, SEND} state_t;

  state_t      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  idx_t        led_q, led_d;
  logic [23:0] shift_q, shift_d;
  logic        framed_q, framed_d;
  logic        data_q, busy_q, frame_done_q;

  logic [23:0]         fbuf_q [NUM_LEDS];
  logic [NUM_LEDS-1:0] wr_en;
  idx_t                fetch_idx;
  logic [23:0]         fetch_word;

  // Out-of-range indices match no entry, so such writes vanish.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_wr
      assign wr_en[gi] = write && (led_num == 8'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LEDS; i++) fbuf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (wr_en[i]) fbuf_q[i] <= rgb_data;
      end
    end
  end

  assign fetch_idx = (state_q == SEND) ? idx_t'(led_q + 1'b1) : '0;

  always_comb begin
    fetch_word = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (fetch_idx == idx_t'(i)) fetch_word = fbuf_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LATCH;
      cnt_q    <= '0;
      bit_q    <= '0;
      led_q    <= '0;
      shift_q  <= '0;
      framed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      led_q    <= led_d;
      shift_q  <= shift_d;
      framed_q <= framed_d;
    end
  end

  // The buffer word is sampled on the same edge that enters SEND, so a write
  // landing on that edge reaches the buffer but not the shift register.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    led_d    = led_q;
    shift_d  = shift_q;
    framed_d = framed_q;
    case (state_q)
      LATCH: begin
        if (cnt_q == RST_LAST) begin
          state_d = SEND;
          cnt_d   = '0;
          bit_d   = 5'd23;
          led_d   = '0;
          shift_d = fetch_word;
        end
      end
      SEND: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q != 5'd0) begin
            bit_d   = bit_q - 1'b1;
            shift_d = {shift_q[22:0], 1'b0};
          end else if (led_q != LAST_LED) begin
            led_d   = led_q + 1'b1;
            bit_d   = 5'd23;
            shift_d = fetch_word;
          end else begin
            state_d  = LATCH;
            framed_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = LATCH;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered line outputs; frame_done fires on the first LATCH cycle that
  // follows a transmitted frame, never on the gap right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      data_q       <= (state_q == SEND) && (cnt_q < (shift_q[23] ? T1H_C : T0H_C));
      busy_q       <= (state_q == SEND);
      frame_done_q <= (state_q == LATCH) && (cnt_q == '0) && framed_q;
    end
  end

  assign data       = data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_wled_serializer.sv
// Directed bench for wled_serializer at 27 MHz, 2 LEDs, 2 us latch gap
// (T_RST=54, T_BIT=33, T0H=9, T1H=18, frame period 1638 cycles).
module tb_wled_serializer;

  logic        clk;
  logic        rst_n;
  logic [23:0] rgb_data;
  logic [7:0]  led_num;
  logic        write;
  logic        data;
  logic        busy;
  logic        frame_done;

  int total;
  int bad;
  int cyc;
  int fd_prev;
  int fd_last;

  int          sch_t[$];
  logic [7:0]  sch_l[$];
  logic [23:0] sch_d[$];

  wled_serializer #(.CLK_MHZ(27), .NUM_LEDS(2), .RESET_US(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rgb_data   (rgb_data),
    .led_num    (led_num),
    .write      (write),
    .data       (data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive a scheduled write (if due at this key) for exactly one edge.
  task automatic step(input int key);
    if (sch_t.size() > 0 && sch_t[0] == key) begin
      write    = 1'b1;
      led_num  = sch_l[0];
      rgb_data = sch_d[0];
      void'(sch_t.pop_front());
      void'(sch_l.pop_front());
      void'(sch_d.pop_front());
    end
    tick();
    write = 1'b0;
  endtask

  task automatic sched(input int key, input logic [7:0] l, input logic [23:0] d);
    sch_t.push_back(key);
    sch_l.push_back(l);
    sch_d.push_back(d);
  endtask

  // Entered on the first busy sample of a frame; ends one sample after frame_done.
  task automatic read_frame(input string tag, input logic [47:0] exp_bits);
    logic [47:0] bits;
    int sb;
    int bb;
    sb = 0;
    bb = 0;
    bits = '0;
    for (int b = 0; b < 48; b++) begin
      int hi;
      bit fell;
      hi = 0;
      fell = 1'b0;
      for (int c = 0; c < 33; c++) begin
        if (busy !== 1'b1) bb++;
        if (data === 1'b1) begin
          hi++;
          if (fell) sb++;
        end else begin
          fell = 1'b1;
        end
        if (b * 33 + c != 1583) step(1000 + b * 33 + c);
      end
      bits[47 - b] = (hi == 18);
      if (hi != 9 && hi != 18) sb++;
    end
    chk({tag, "_shape"}, 64'(sb), 64'd0);
    chk({tag, "_busy"}, 64'(bb), 64'd0);
    chk({tag, "_bits"}, 64'(bits), 64'(exp_bits));
    tick();
    chk({tag, "_fd_hi"}, 64'(frame_done), 64'd1);
    chk({tag, "_fd_line"}, 64'({data, busy}), 64'd0);
    fd_last = cyc;
    if (fd_prev >= 0) chk({tag, "_fd_period"}, 64'(fd_last - fd_prev), 64'd1638);
    fd_prev = fd_last;
    tick();
    chk({tag, "_fd_lo"}, 64'(frame_done), 64'd0);
  endtask

  // Entered one sample after frame_done; ends on the first busy sample.
  task automatic gap(input string tag);
    int j;
    int lb;
    j = 1;
    lb = 0;
    while (busy !== 1'b1 && j < 200) begin
      if (data !== 1'b0 || frame_done !== 1'b0) lb++;
      step(j);
      j++;
    end
    chk({tag, "_gap_len"}, 64'(j), 64'd54);
    chk({tag, "_gap_line"}, 64'(lb), 64'd0);
  endtask

  // Reset release: 54 idle samples, then busy and the first high.
  task automatic after_release(input string tag);
    int lb;
    lb = 0;
    cyc = -1;
    fd_prev = -1;
    for (int k = 0; k < 54; k++) begin
      tick();
      if (data !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) lb++;
    end
    chk({tag, "_idle"}, 64'(lb), 64'd0);
    tick();
    chk({tag, "_busy_rise"}, 64'({busy, data}), 64'b11);
    chk({tag, "_rise_cyc"}, 64'(cyc), 64'd54);
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    fd_prev = -1;
    fd_last = 0;
    rst_n = 1'b0;
    write = 1'b0;
    led_num = '0;
    rgb_data = '0;

    repeat (3) tick();
    chk("reset_outputs", 64'({data, busy, frame_done}), 64'd0);
    rst_n = 1'b1;

    after_release("r1");
    read_frame("f1_blank", 48'h0);
    chk("f1_fd_cyc", 64'(fd_last), 64'd1638);

    sched(1, 8'd0, 24'hFF0000);
    sched(2, 8'd2, 24'hFFFFFF);
    gap("g2");
    read_frame("f2_led0_red", {24'hFF0000, 24'h000000});

    sched(1010, 8'd1, 24'h0000FF);
    sched(1011, 8'd0, 24'hFFFFFF);
    gap("g3");
    read_frame("f3_midframe", {24'hFF0000, 24'h0000FF});

    sched(52, 8'd0, 24'h00FF00);
    gap("g4");
    read_frame("f4_load_edge", {24'hFFFFFF, 24'h0000FF});

    gap("g5");
    read_frame("f5_after_load", {24'h00FF00, 24'h0000FF});

    gap("g6");
    chk("pre_reset_high", 64'(data), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_line", 64'({data, busy, frame_done}), 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;

    after_release("r2");
    read_frame("f7_cleared", 48'h0);
    chk("f7_fd_cyc", 64'(fd_last), 64'd1638);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wled_serializer.md
# wled_serializer

Frame-buffered WS2812 line driver that sits directly downstream of the LED bar/pattern generators in a riocore plugin. It accepts per-LED colour writes (24-bit GRB word plus LED index plus write strobe), stores them in an internal frame buffer and continuously refreshes the LED chain. Each refresh is an NRZ bit stream followed by a latch gap. Upstream generators can write at any rate without waiting for the line.

## Interface
- CLK_MHZ, 27: system clock frequency in MHz; all bit timings are derived from it.
- NUM_LEDS, 12: number of LEDs in the chain, 1..255.
- RESET_US, 80: latch gap length in microseconds.

- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- rgb_data  input  24  colour word {G[7:0], R[7:0], B[7:0]}; bit 23 goes out first.
- led_num  input  8  buffer index to write; index 0 is sent first on the line.
- write  input  1  single-cycle write strobe; stores rgb_data at led_num.
- data  output  1  serial line to the first LED's DIN.
- busy  output  1  high while LED bits are being sent; low during the latch gap.
- frame_done  output  1  one-cycle pulse when the last bit of a frame has completed.

## Operation
- Derived constants use integer division, truncating:
  - T_BIT = CLK_MHZ*1250/1000
  - T0H = CLK_MHZ*350/1000
  - T1H = CLK_MHZ*700/1000
  - T_RST = CLK_MHZ*RESET_US
  - At 27 MHz these give 33, 9, 18 and 2160 cycles.
- Frame buffer: NUM_LEDS x 24 bits, cleared to 0 by rst_n.
- Write port:
  - When write=1 and led_num < NUM_LEDS, the entry is updated on that clock edge.
  - When led_num >= NUM_LEDS, the write is ignored with no side effects.
  - Writes are accepted in every state, with no backpressure.
- State machine states: LATCH, LOAD, SEND.
  - After reset the machine is in LATCH, so a full latch gap always precedes the first frame.
  - LATCH: data=0, busy=0. Counts T_RST cycles, then goes to LOAD with LED index 0.
  - LOAD: zero-length. The buffer entry for the current LED is copied into a 24-bit shift register on the last cycle of the previous state, bit counter = 23.
  - SEND: sends each bit over T_BIT cycles.
    - data=1 for TH cycles, where TH=T1H if the current bit is 1 and T0H if it is 0.
    - data=0 for the remaining T_BIT-TH cycles.
    - After bit 0 of an LED: if the LED index < NUM_LEDS-1, increment the index and LOAD; otherwise go to LATCH.
- frame_done is high on the first cycle of each LATCH entered after a frame. It does not pulse for the post-reset LATCH.
- Snapshot rule:
  - An LED's colour is sampled at its LOAD.
  - A write to an LED not yet loaded in the current frame appears in that frame.
  - A write to an LED already loaded appears in the next frame.
  - A write landing on the same cycle as that entry's load: the shift register gets the old value and the buffer keeps the new one.
- Reset mid-operation: data=0, busy=0 and frame_done=0 immediately, asynchronously. The buffer, counters and state return to their reset values. The partial frame is abandoned.

## Timing
- Reset values: data=0, busy=0, frame_done=0, state=LATCH, buffer all zero.
- Cycle 0 is the first rising clk edge after rst_n deasserts.
  - data first rises and busy rises at cycle T_RST.
- Frame period is exactly NUM_LEDS*24*T_BIT + T_RST cycles, with no idle cycles between bits or LEDs.
- Write-to-line latency is at most one frame period plus one LED time. No combinational path runs from any input to any output.

## Test plan
The bench uses CLK_MHZ=27, NUM_LEDS=2, RESET_US=2, giving T_RST=54 and a frame of 48 bits.

- Reset release, no writes:
  - data=0 and busy=0 for cycles 0-53.
  - busy=1 at cycle 54.
  - 48 zero-codes follow, each high 9 / low 24.
  - frame_done pulses at cycle 54+1584=1638.
- Write LED0=24'hFF0000 before the first frame:
  - The first 8 bits are one-codes (high 18 / low 15), followed by 40 zero-codes.
  - Every later frame is identical.
- Write with led_num=2, value 24'hFFFFFF:
  - Ignored; the line stream stays all zero-codes.
- While LED0 is shifting, write LED1=24'h0000FF and LED0=24'hFFFFFF:
  - The current frame shows the LED1 change (last 8 bits are ones).
  - The LED0 change appears only in the next frame.
- Write LED0 on the exact cycle of its LOAD:
  - The current frame sends the old value; the next frame sends the new value.
- Assert rst_n low mid-bit while data=1:
  - data drops without waiting for a clock edge.
  - After release: a full 54-cycle gap, then all zero-codes, proving the buffer was cleared.
- Consecutive frame_done pulses are exactly 1638 cycles apart and each is one cycle wide.
